serial_add_ctrl: RTL

Bit-serial addition sequencer built around the team's single-bit full-adder cell. It accepts a WIDTH-bit operand pair plus carry-in on a start pulse and drives one full-adder instance LSB-first, one bit per clock. It holds the carry in a flip-flop between bits and presents the registered sum and carry-out with a one-cycle done pulse. It sits between a requesting controller and the shared 1-bit adder datapath, trading latency for area.

---
 rtl/serial_add_ctrl_pkg.sv | 11 +
 rtl/serial_add_ctrl_if.sv | 23 ++
 rtl/serial_add_ctrl_fa.sv | 16 +
 rtl/serial_add_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// State encoding shared by the serial adder sequencer.
package adder_pkg;

    // Encoding 2'd3 is unused; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a controller and the serial adder sequencer.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, Sum, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, Sum, Cout
    );
endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder cell shared by the bit-serial datapath.
module fullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    // Pure combinational sum and carry.
    always_comb begin
        Sum  = A ^ B ^ Cin;
        Cout = (A & B) | (Cin & (A ^ B));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder evaluation per clock, LSB first.
module serial_add_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_d;
    logic             last_bit;

    fullAdder u_fa (
        .A    (opa_q[0]),
        .B    (opb_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // Next result word, counter increment and last-bit detect for the RUN step.
    always_comb begin
        res_d          = res_q >> 1;
        res_d[WIDTH-1] = fa_sum;
        cnt_d          = cnt_q + CW'(1);
        last_bit       = (cnt_q == CW'(WIDTH - 1));
    end

    // Sequencer FSM with registered operands, carry, count and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        opa_q   <= bus.A;
                        opb_q   <= bus.B;
                        carry_q <= bus.Cin;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_d;
                    res_q   <= res_d;
                    if (last_bit) begin
                        // Commit includes the bit being added on this edge.
                        sum_q   <= res_d;
                        cout_q  <= fa_cout;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;

endmodule
